pipeline_sequencer: RTL and testbench

Sequential stall/flush sequencer for the ERV25 5-stage pipeline (IF, ID, RR, EX, WB). It merges three stall sources into one set of latch enables, flushes and a PC enable:
- combinational data-hazard stall from hazard detection;
- multi-cycle memory accesses in EX, which wait for memory ready, with a timeout;
- multi-cycle ALU ops in EX, which wait for a done signal.
It also applies branch flushes and keeps a saturating stall-cycle performance counter.

---
 rtl/erv25_pipe_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_sequencer.sv | 136 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/erv25_pipe_pkg.sv
// Shared definitions for the ERV25 pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package erv25_pipe_pkg;

  // Sequencer FSM states; encoding 3 is unused and recovers to RUN
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_WAIT  = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 16;

  // Pipeline stage indices
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_RR = 2;
  localparam int STG_EX = 3;
  localparam int STG_WB = 4;

  // One bundle of pipeline control outputs
  typedef struct packed {
    logic pc_en;
    logic en_fd;
    logic en_dr;
    logic en_re;
    logic en_ew;
    logic fl_fd;
    logic fl_dr;
    logic fl_re;
    logic fl_ew;
  } ctrl_t;

  // Everything moves, nothing flushed
  localparam ctrl_t CTRL_FREE   = '{pc_en: 1'b1, en_fd: 1'b1, en_dr: 1'b1, en_re: 1'b1,
                                    en_ew: 1'b1, fl_fd: 1'b0, fl_dr: 1'b0, fl_re: 1'b0,
                                    fl_ew: 1'b0};
  // Hold EX, feed a bubble into WB
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, en_fd: 1'b0, en_dr: 1'b0, en_re: 1'b0,
                                    en_ew: 1'b1, fl_fd: 1'b0, fl_dr: 1'b0, fl_re: 1'b0,
                                    fl_ew: 1'b1};
  // Everything quiet while reset is held
  localparam ctrl_t CTRL_OFF    = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: q reflects inc/clr one clock after they are sampled.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Clear beats increment; increment stops at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Merges hazard, memory-wait and multi-cycle-ALU stalls plus branch flushes into latch controls.
// Latency: controls are combinational (Mealy) from state and inputs; state updates each clock.
// Backpressure: freezes IF..EX while memory or the multi-cycle unit is busy; memory wait aborts on timeout.
module pipeline_sequencer
  import erv25_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hz_stall,
  input  logic              branch_E,
  input  logic              mem_req_E,
  input  logic              mem_ready,
  input  logic              mc_start_E,
  input  logic              mc_done,
  input  logic              perf_clear,
  output logic              pc_enable,
  output logic              enable_F_D,
  output logic              enable_D_R,
  output logic              enable_R_E,
  output logic              enable_E_W,
  output logic              flush_F_D,
  output logic              flush_D_R,
  output logic              flush_R_E,
  output logic              flush_E_W,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [1:0]        state_o
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       err_set;
  ctrl_t      ctrl;

  // Decide this cycle's controls and the next state from the current state and requests
  always_comb begin
    ctrl         = CTRL_FREE;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req_E && !mem_ready) begin
          ctrl         = CTRL_FREEZE;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (mem_req_E) begin
          ctrl = CTRL_FREE;
        end else if (mc_start_E && !mc_done) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MC_WAIT;
        end else if (branch_E) begin
          ctrl.fl_fd = 1'b1;
          ctrl.fl_dr = 1'b1;
        end else if (hz_stall) begin
          ctrl.en_fd = 1'b0;
          ctrl.en_dr = 1'b0;
          ctrl.fl_re = 1'b1;
          ctrl.pc_en = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          // Give up on the access: let the pipe move but drop what leaves EX
          ctrl.fl_ew   = 1'b1;
          err_set      = 1'b1;
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          ctrl         = CTRL_FREEZE;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          state_nxt = ST_RUN;
        end else begin
          ctrl = CTRL_FREEZE;
        end
      end
      default: begin
        ctrl         = CTRL_FREEZE;
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
    if (reset) begin
      ctrl = CTRL_OFF;
    end
  end

  // Register FSM state, wait counter and the sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_RUN;
      wait_cnt        <= 8'd0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) begin
        mem_timeout_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctrl.pc_en),
    .clr   (perf_clear),
    .q     (stall_cycles)
  );

  assign pc_enable  = ctrl.pc_en;
  assign enable_F_D = ctrl.en_fd;
  assign enable_D_R = ctrl.en_dr;
  assign enable_R_E = ctrl.en_re;
  assign enable_E_W = ctrl.en_ew;
  assign flush_F_D  = ctrl.fl_fd;
  assign flush_D_R  = ctrl.fl_dr;
  assign flush_R_E  = ctrl.fl_re;
  assign flush_E_W  = ctrl.fl_ew;
  assign state_o    = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized + directed bench for pipeline_sequencer with a scoreboard-fed monitor.
// Latency: each driven cycle is checked on the following falling edge.
// Backpressure: n/a.
module tb_pipeline_sequencer;

  localparam int TO     = 4;
  localparam int PW     = 4;
  localparam int CNTMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset, hz_stall, branch_E, mem_req_E, mem_ready, mc_start_E, mc_done, perf_clear;
  logic pc_enable, enable_F_D, enable_D_R, enable_R_E, enable_E_W;
  logic flush_F_D, flush_D_R, flush_R_E, flush_E_W, mem_timeout_err;
  logic [PW-1:0] stall_cycles;
  logic [1:0] state_o;

  pipeline_sequencer #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .branch_E(branch_E),
    .mem_req_E(mem_req_E), .mem_ready(mem_ready), .mc_start_E(mc_start_E),
    .mc_done(mc_done), .perf_clear(perf_clear), .pc_enable(pc_enable),
    .enable_F_D(enable_F_D), .enable_D_R(enable_D_R), .enable_R_E(enable_R_E),
    .enable_E_W(enable_E_W), .flush_F_D(flush_F_D), .flush_D_R(flush_D_R),
    .flush_R_E(flush_R_E), .flush_E_W(flush_E_W), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] outs;   // {pc, en F_D,D_R,R_E,E_W, fl F_D,D_R,R_E,E_W}
    logic [1:0] st;
    logic       err;
    logic [PW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: where the pipeline is waiting and for how long
  bit waiting_mem = 0;
  bit waiting_mc  = 0;
  int waited      = 0;
  bit err_seen    = 0;
  int stalls      = 0;

  localparam logic [8:0] FREE   = 9'b1_1111_0000;
  localparam logic [8:0] FREEZE = 9'b0_0001_0001;

  task automatic cyc(input bit rs, input bit hz, input bit br, input bit mq, input bit mr,
                     input bit ms, input bit md, input bit pcl);
    exp_t e;
    logic [8:0] o;
    @(posedge clk);
    #1;
    reset = rs; hz_stall = hz; branch_E = br; mem_req_E = mq; mem_ready = mr;
    mc_start_E = ms; mc_done = md; perf_clear = pcl;
    e.st  = waiting_mem ? 2'd1 : (waiting_mc ? 2'd2 : 2'd0);
    e.err = err_seen;
    e.cnt = PW'(stalls);
    if (rs) begin
      e.outs = 9'b0; e.st = 2'd0; e.err = 1'b0; e.cnt = '0;
      waiting_mem = 0; waiting_mc = 0; waited = 0; err_seen = 0; stalls = 0;
      exp_q.push_back(e);
      return;
    end
    if (waiting_mem) begin
      if (mr) begin
        o = FREE; waiting_mem = 0;
      end else if (waited == TO - 1) begin
        o = FREE | 9'b0_0000_0001; waiting_mem = 0; err_seen = 1;
      end else begin
        o = FREEZE; waited++;
      end
    end else if (waiting_mc) begin
      if (md) begin
        o = FREE; waiting_mc = 0;
      end else o = FREEZE;
    end else if (mq && !mr) begin
      o = FREEZE; waiting_mem = 1; waited = 1;
    end else if (mq) begin
      o = FREE;
    end else if (ms && !md) begin
      o = FREEZE; waiting_mc = 1;
    end else if (br) begin
      o = 9'b1_1111_1100;
    end else if (hz) begin
      o = 9'b0_0011_0010;
    end else begin
      o = FREE;
    end
    e.outs = o;
    if (pcl) stalls = 0;
    else if (!o[8] && stalls < CNTMAX) stalls++;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: pop one expectation per driven cycle and compare the DUT view
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e = exp_q.pop_front();
      got = {pc_enable, enable_F_D, enable_D_R, enable_R_E, enable_E_W,
             flush_F_D, flush_D_R, flush_R_E, flush_E_W};
      chk("ctrl_outputs", int'(got), int'(e.outs));
      chk("state_o", int'(state_o), int'(e.st));
      chk("mem_timeout_err", int'(mem_timeout_err), int'(e.err));
      chk("stall_cycles", int'(stall_cycles), int'(e.cnt));
    end
  end

  initial begin
    reset = 1; hz_stall = 0; branch_E = 0; mem_req_E = 0; mem_ready = 0;
    mc_start_E = 0; mc_done = 0; perf_clear = 0;
    // reset held, then idle
    cyc(1,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0);
    repeat (3) cyc(0,0,0,0,0,0,0,0);
    // memory with three wait cycles then ready
    repeat (3) cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,1,1,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // memory never ready: timeout abort
    repeat (6) cyc(0,0,0,1,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // branch together with hazard
    cyc(0,1,1,0,0,0,0,1);
    cyc(0,1,1,0,0,0,0,0);
    // multi-cycle op done after 5 cycles with hazard throughout
    repeat (5) cyc(0,1,0,0,0,1,0,0);
    cyc(0,1,0,0,0,1,1,0);
    cyc(0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // saturate the counter, then clear
    repeat (20) cyc(0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,1);
    cyc(0,0,0,0,0,0,0,0);
    // reset in the middle of a memory wait
    repeat (2) cyc(0,0,0,1,0,0,0,0);
    cyc(1,0,0,1,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
